burst_addr_gen: RTL
===================

BURST_ADDR_GEN -- requirements
Module: burst_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter LEN_W, default 4, burst length width.
REQ-003 SHALL have parameter ADDR_INCR, default 1, address step per beat.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load_len  input  1  one-cycle strobe: capture burst_len_in (driven by send_burst_len_data).
REQ-007 SHALL have port burst_len_in  input  LEN_W  parallel burst length from burst-length STP.
REQ-008 SHALL have port load_addr  input  1  one-cycle strobe: capture addr_in (driven by send_addr_data).
REQ-009 SHALL have port addr_in  input  ADDR_W  parallel initial address from address STP.
REQ-010 SHALL have port counter_en  input  1  beat step request; each high cycle is one step.
REQ-011 SHALL have port adder_en  input  1  level; enables the address increment on a step.
REQ-012 SHALL have port addr_out  output  ADDR_W  current burst address, parallel input to the address PTS.
REQ-013 SHALL have port beat_count  output  LEN_W  number of steps taken since load_addr.
REQ-014 SHALL have port stop_signal  output  1  level; burst complete, consumed by burst_ctrl.
REQ-015 SHALL have port busy  output  1  high while in RUN.

Function
REQ-016 SHALL implement states IDLE, ARMED, RUN, DONE, encoded in a registered state variable.
REQ-017 SHALL, in any state, on load_len: len_reg <= burst_len_in; beat_count <= 0; stop_signal <= 0; state <= ARMED.
REQ-018 SHALL, on load_addr in ARMED, DONE or RUN: addr_out <= addr_in; beat_count <= 0; stop_signal <= 0; state <= RUN, or DONE with stop_signal <= 1 if len_reg == 0.
REQ-019 SHALL ignore load_addr in IDLE (no length captured): addr_out and state unchanged.
REQ-020 SHALL, when load_len and load_addr are high in the same cycle, capture both and evaluate REQ-018 using burst_len_in as the length.
REQ-021 SHALL, in RUN with counter_en = 1 and no load strobe, take one step: beat_count <= beat_count + 1; addr_out <= addr_out + ADDR_INCR if adder_en = 1, else hold.
REQ-022 SHALL give load_addr priority over a step in the same cycle; that step is discarded.
REQ-023 SHALL, on the step where beat_count + 1 == len_reg, enter DONE and assert stop_signal on the next clock edge (one-cycle registered latency).
REQ-024 SHALL compute the address modulo 2^ADDR_W (wrap-around with no flag; e.g. 16'hFFFF + 1 = 16'h0000).
REQ-025 SHALL, in IDLE, ARMED and DONE, ignore counter_en and adder_en; addr_out and beat_count hold.
REQ-026 SHALL hold stop_signal high in DONE until the next load_len or load_addr.
REQ-027 SHALL drive busy = 1 exactly when state == RUN; all outputs are registered, with no combinational path from input to output.

Reset
REQ-028 SHALL, on rst = 1, immediately set state = IDLE, len_reg = 0, addr_out = 0, beat_count = 0, stop_signal = 0, busy = 0, regardless of the clock.
REQ-029 SHALL, on reset asserted mid-burst, abandon the burst; after release it requires load_len followed by load_addr to restart.

Verification
REQ-030 SHALL cover a basic burst: load_len(4), then load_addr(16'h0100), then 4 single-cycle counter_en pulses with adder_en = 1 -> addr_out = 0100, 0101, 0102, 0103, 0104; stop_signal = 1 the cycle after the 4th step; busy = 0.
REQ-031 SHALL cover wrap-around: len 3, addr 16'hFFFE, 3 steps -> addr_out = FFFF, 0000, 0001; stop_signal = 1.
REQ-032 SHALL cover simultaneous events: load_addr(16'h0200) and counter_en high in the same cycle -> addr_out = 0200, beat_count = 0, no step counted; with load_len(2) and load_addr in the same cycle -> burst of 2 uses length 2.
REQ-033 SHALL cover zero length and ignored inputs: load_len(0) then load_addr(16'h0050) -> stop_signal = 1 next cycle, no steps taken; counter_en pulses in DONE and IDLE -> no change; load_addr in IDLE -> ignored.
REQ-034 SHALL cover adder_en gating: len 4, adder_en = 0 on step 2 -> addr_out = 0100, 0101, 0101, 0102, 0103; beat_count = 4; stop_signal = 1.
REQ-035 SHALL cover reset mid-burst: after 2 steps, assert rst asynchronously between clock edges -> all outputs 0 immediately; counter_en after release -> no change.

Source files
------------

// File: rtl/burst_addr_gen.sv
// Burst address generator: captures a burst length and a start address,
// then steps the address and beat count on each counter_en until the burst completes.
//
// Ports:
//   clk, rst (async, active-high)
//   load_len/burst_len_in   : capture the burst length (enters ARMED)
//   load_addr/addr_in       : capture the start address (enters RUN or DONE)
//   counter_en, adder_en    : beat step request and address increment enable
//   addr_out, beat_count    : registered current address and step count
//   stop_signal, busy       : burst complete (level) and running flags
module burst_addr_gen #(
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 4,
  parameter int ADDR_INCR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_len,
  input  logic [LEN_W-1:0]  burst_len_in,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              counter_en,
  input  logic              adder_en,
  output logic [ADDR_W-1:0] addr_out,
  output logic [LEN_W-1:0]  beat_count,
  output logic              stop_signal,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] INCR = ADDR_W'(ADDR_INCR);

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_beat;
  logic              r_stop;

  logic [LEN_W-1:0]  w_len_eff;
  logic [LEN_W-1:0]  w_beat_nxt;
  logic              w_addr_ok;
  logic              w_step;

  // A length strobed in the same cycle as the address is the one used.
  assign w_len_eff  = load_len ? burst_len_in : r_len;
  // An address with no length ever captured (IDLE) is dropped.
  assign w_addr_ok  = load_addr && ((r_state != S_IDLE) || load_len);
  assign w_step     = (r_state == S_RUN) && counter_en;
  assign w_beat_nxt = r_beat + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_addr  <= '0;
      r_beat  <= '0;
      r_stop  <= 1'b0;
    end else begin
      if (load_len) begin
        r_len <= burst_len_in;
      end
      if (w_addr_ok) begin
        r_addr <= addr_in;
        r_beat <= '0;
        if (w_len_eff == '0) begin
          r_state <= S_DONE;
          r_stop  <= 1'b1;
        end else begin
          r_state <= S_RUN;
          r_stop  <= 1'b0;
        end
      end else if (load_len) begin
        r_beat  <= '0;
        r_stop  <= 1'b0;
        r_state <= S_ARMED;
      end else if (w_step) begin
        r_beat <= w_beat_nxt;
        if (adder_en) begin
          r_addr <= r_addr + INCR;
        end
        if (w_beat_nxt == r_len) begin
          r_state <= S_DONE;
          r_stop  <= 1'b1;
        end
      end
    end
  end

  assign addr_out    = r_addr;
  assign beat_count  = r_beat;
  assign stop_signal = r_stop;
  assign busy        = (r_state == S_RUN);

endmodule
